// File: rtl/spi_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_engine
// Description : Byte-wide SPI master sequencer behind a 4-register CPU port.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_engine #(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RESET = 3
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       WE,
    input  logic [1:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    input  logic [2:0] MISO,
    output logic       MOSI,
    output logic       SCK,
    output logic [1:0] nSS,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [1:0]           c_addr_data = 2'd0;
    localparam logic [1:0]           c_addr_ctrl = 2'd1;
    localparam logic [1:0]           c_addr_div  = 2'd2;
    localparam logic [DIV_WIDTH-1:0] c_div_init  = DIV_WIDTH'(DIV_RESET);
    localparam logic [DIV_WIDTH-1:0] c_cnt_one   = DIV_WIDTH'(1);
    localparam logic [4:0]           c_last_tog  = 5'd16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [4:0]           r_tcnt;
    logic [1:0]           r_nss;
    logic                 r_cpol;
    logic                 r_cpha;
    logic                 r_ovr;
    logic                 r_sck;
    logic                 r_mosi;
    logic                 r_done;

    logic                 w_miso;
    logic [4:0]           w_tnext;
    logic [7:0]           w_div_rd;
    logic [DIV_WIDTH-1:0] w_div_wr;

    // The divider register may be wider or narrower than the 8-bit bus.
    generate
        if (DIV_WIDTH == 8) begin : g_div_exact
            assign w_div_rd = r_div;
            assign w_div_wr = WDATA;
        end else if (DIV_WIDTH > 8) begin : g_div_wide
            assign w_div_rd = r_div[7:0];
            assign w_div_wr = {{(DIV_WIDTH-8){1'b0}}, WDATA};
        end else begin : g_div_narrow
            assign w_div_rd = {{(8-DIV_WIDTH){1'b0}}, r_div};
            assign w_div_wr = WDATA[DIV_WIDTH-1:0];
        end
    endgenerate

    // dev0 wins when both selects are low; MISO[2] when nothing is selected
    assign w_miso  = !r_nss[0] ? MISO[0] : (!r_nss[1] ? MISO[1] : MISO[2]);
    assign w_tnext = r_tcnt + 5'd1;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= ST_IDLE;
            r_shift <= 8'h00;
            r_rx    <= 8'h00;
            r_div   <= c_div_init;
            r_cnt   <= '0;
            r_tcnt  <= 5'd0;
            r_nss   <= 2'b11;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_ovr   <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (WE && (ADDR == c_addr_ctrl) && WDATA[7]) begin
                r_ovr <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_sck <= r_cpol;
                    if (WE) begin
                        case (ADDR)
                            c_addr_data: begin
                                r_shift <= WDATA;
                                r_cnt   <= '0;
                                r_tcnt  <= 5'd0;
                                r_state <= ST_SHIFT;
                                if (!r_cpha) begin
                                    r_mosi <= WDATA[7];
                                end
                            end
                            c_addr_ctrl: begin
                                r_nss  <= WDATA[1:0];
                                r_cpol <= WDATA[2];
                                r_cpha <= WDATA[3];
                                r_sck  <= WDATA[2];
                            end
                            c_addr_div: r_div <= w_div_wr;
                            default: ;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (WE && (ADDR == c_addr_data)) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_cnt == r_div) begin
                        r_cnt  <= '0;
                        r_tcnt <= w_tnext;
                        r_sck  <= ~r_sck;
                        // odd toggles sample in mode 0, even toggles sample in mode 1
                        if (w_tnext[0] ^ r_cpha) begin
                            r_shift <= {r_shift[6:0], w_miso};
                        end else if (w_tnext != c_last_tog) begin
                            r_mosi <= r_shift[7];
                        end
                        if (w_tnext == c_last_tog) begin
                            r_state <= ST_IDLE;
                            r_sck   <= r_cpol;
                            r_done  <= 1'b1;
                            r_rx    <= r_cpha ? {r_shift[6:0], w_miso} : r_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RDATA = 8'h00;
        case (ADDR)
            c_addr_data: RDATA = r_rx;
            c_addr_ctrl: RDATA = {4'b0000, r_cpha, r_cpol, r_nss};
            c_addr_div:  RDATA = w_div_rd;
            default:     RDATA = {BUSY, r_ovr, 3'b000, w_miso, 2'b00};
        endcase
    end

    assign MOSI = r_mosi;
    assign SCK  = r_sck;
    assign nSS  = r_nss;
    assign BUSY = (r_state == ST_SHIFT);
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_byte_engine
// Description : Self-checking bench; a behavioural SPI slave model scores transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_engine;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       WE = 1'b0;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] WDATA = 8'h00;
    logic [7:0] RDATA;
    logic [2:0] MISO = 3'b000;
    logic       MOSI;
    logic       SCK;
    logic [1:0] nSS;
    logic       BUSY;
    logic       DONE;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    spi_byte_engine #(.DIV_WIDTH(8), .DIV_RESET(3)) dut (
        .CLK(CLK), .nRESET(nRESET), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS),
        .BUSY(BUSY), .DONE(DONE)
    );

    typedef struct {
        bit         we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [1:0] raddr;
        logic [7:0] exp;
        string      name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        WE = 1'b1; ADDR = a; WDATA = d;
        @(posedge CLK); #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLK);
        ADDR = a;
        #1 d = RDATA;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge CLK); #1;
            if (DONE) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    // Acts as an SPI slave: presents mb MSB-first on its drive edges and
    // captures MOSI on the sampling edges; scores the transfer afterwards.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] mb, input int dev,
                        input bit cpol, input bit cpha, input int div, input string tag);
        logic [1:0] nss_v;
        logic [7:0] cap = 8'h00;
        logic [7:0] rx;
        logic       slv, prev_sck, prev_mosi;
        int sel, nxt, budget;
        int tog = 0, busy_n = 0, done_n = 0;
        bit ended = 0;
        case (dev)
            0: nss_v = 2'b10;
            1: nss_v = 2'b01;
            2: nss_v = 2'b11;
            default: nss_v = 2'b00;
        endcase
        sel = (dev == 1) ? 1 : ((dev == 2) ? 2 : 0);
        wr(2'd1, {4'b0000, cpha, cpol, nss_v});
        wr(2'd2, div[7:0]);
        slv = cpha ? 1'b0 : mb[7];
        nxt = cpha ? 7 : 6;
        @(negedge CLK);
        MISO = 3'($urandom); MISO[sel] = slv;
        prev_sck = SCK; prev_mosi = MOSI;
        WE = 1'b1; ADDR = 2'd0; WDATA = tx;
        budget = 16 * (div + 1) + 4;
        for (int c = 0; c < budget && !ended; c++) begin
            @(posedge CLK); #1;
            WE = 1'b0;
            if (BUSY) busy_n++;
            if (DONE) done_n++;
            if (SCK !== prev_sck) begin
                tog++;
                if (((tog % 2) == 1) != cpha) cap = {cap[6:0], prev_mosi};
                else if (nxt >= 0) begin slv = mb[nxt]; nxt--; end
            end
            prev_sck = SCK; prev_mosi = MOSI;
            MISO = 3'($urandom); MISO[sel] = slv;
            if (!BUSY) begin
                chk({tag, "_idle_sck"}, SCK, cpol);
                @(posedge CLK); #1;
                if (DONE) done_n++;
                ended = 1;
            end
        end
        chk({tag, "_ended"}, ended, 1);
        chk({tag, "_mosi"}, cap, tx);
        chk({tag, "_toggles"}, tog, 16);
        chk({tag, "_busy_cycles"}, busy_n, 16 * (div + 1));
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_nss"}, nSS, nss_v);
        rd(2'd0, rx);
        chk({tag, "_rx"}, rx, mb);
    endtask

    initial begin
        vec_t       vecs[10];
        logic [7:0] v;
        int         tog;

        vecs[0] = '{0, 2'd0, 8'h00, 2'd0, 8'h00, "rst_data"};
        vecs[1] = '{0, 2'd0, 8'h00, 2'd1, 8'h03, "rst_ctrl"};
        vecs[2] = '{0, 2'd0, 8'h00, 2'd2, 8'h03, "rst_div"};
        vecs[3] = '{0, 2'd0, 8'h00, 2'd3, 8'h00, "rst_status"};
        vecs[4] = '{1, 2'd1, 8'h0E, 2'd1, 8'h0E, "ctrl_0e"};
        vecs[5] = '{1, 2'd1, 8'h8E, 2'd1, 8'h0E, "ctrl_bit7_unstored"};
        vecs[6] = '{1, 2'd2, 8'hFF, 2'd2, 8'hFF, "div_ff"};
        vecs[7] = '{1, 2'd3, 8'h55, 2'd3, 8'h00, "status_wr_ignored"};
        vecs[8] = '{1, 2'd2, 8'h00, 2'd2, 8'h00, "div_00"};
        vecs[9] = '{1, 2'd1, 8'h00, 2'd1, 8'h00, "ctrl_00"};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_nss", nSS, 2'b11);
        chk("rst_sck", SCK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        @(negedge CLK); nRESET = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, v);
            chk(vecs[i].name, v, vecs[i].exp);
        end

        // idle SCK follows CPOL; STATUS shows the muxed MISO line
        wr(2'd1, 8'h06);
        chk("idle_cpol1_sck", SCK, 1'b1);
        MISO = 3'b001;
        rd(2'd3, v);
        chk("status_miso_dev0", v, 8'h04);
        wr(2'd1, 8'h02);
        chk("idle_cpol0_sck", SCK, 1'b0);

        xfer(8'hA5, 8'hA5, 0, 1'b0, 1'b0, 0, "m0_a5");
        xfer(8'h3C, 8'hFF, 0, 1'b1, 1'b1, 3, "m3_3c");
        xfer(8'h5A, 8'hC3, 1, 1'b0, 1'b0, 1, "dev1_c3");
        xfer(8'h69, 8'h96, 2, 1'b0, 1'b1, 2, "none_sel");
        for (int i = 0; i < 8; i++) begin
            xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), "rand");
        end

        // writes while busy are ignored, DATA sets the sticky overrun flag
        wr(2'd1, 8'h02); wr(2'd2, 8'h03);
        MISO = 3'b111;
        wr(2'd0, 8'h96);
        wr(2'd0, 8'h11); wr(2'd1, 8'h03); wr(2'd2, 8'h07);
        chk("busy_nss_frozen", nSS, 2'b10);
        rd(2'd2, v); chk("busy_div_frozen", v, 8'h03);
        rd(2'd1, v); chk("busy_ctrl_frozen", v, 8'h02);
        rd(2'd3, v); chk("busy_status_ovr", v, 8'hC4);
        wait_done(100, "busy_done_seen");
        rd(2'd0, v); chk("busy_rx", v, 8'hFF);
        wr(2'd1, 8'h80);
        rd(2'd3, v); chk("ovr_cleared", v, 8'h04);

        // DATA write landing on the completion edge is treated as busy
        MISO = 3'b000;
        wr(2'd1, 8'h02); wr(2'd2, 8'h00); wr(2'd0, 8'h81);
        repeat (15) @(posedge CLK);
        @(negedge CLK); WE = 1'b1; ADDR = 2'd0; WDATA = 8'h42;
        @(posedge CLK); #1; WE = 1'b0;
        chk("fall_edge_busy", BUSY, 1'b0);
        chk("fall_edge_done", DONE, 1'b1);
        @(posedge CLK); #1;
        chk("fall_edge_no_start", BUSY, 1'b0);
        rd(2'd3, v); chk("fall_edge_ovr", v, 8'h40);

        // a DATA write in the DONE cycle starts a new transfer
        wr(2'd1, 8'h82);
        wr(2'd0, 8'h33);
        wait_done(40, "b2b_first_done");
        wr(2'd0, 8'h44);
        chk("b2b_second_start", BUSY, 1'b1);
        wait_done(40, "b2b_second_done");

        // asynchronous reset in the middle of a transfer
        wr(2'd2, 8'h03); wr(2'd0, 8'hF0);
        tog = 0;
        v = {7'd0, SCK};
        for (int c = 0; c < 100 && tog < 7; c++) begin
            @(posedge CLK); #1;
            if (SCK !== v[0]) tog++;
            v = {7'd0, SCK};
        end
        chk("midrst_reached_tog7", tog, 7);
        #2 nRESET = 1'b0;
        #1;
        chk("midrst_sck", SCK, 1'b0);
        chk("midrst_nss", nSS, 2'b11);
        chk("midrst_busy", BUSY, 1'b0);
        tog = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (DONE) tog++;
        end
        @(negedge CLK); nRESET = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            if (DONE) tog++;
        end
        chk("midrst_no_done", tog, 0);
        rd(2'd0, v); chk("midrst_rx", v, 8'h00);
        rd(2'd1, v); chk("midrst_ctrl", v, 8'h03);
        rd(2'd2, v); chk("midrst_div", v, 8'h03);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
